// File: rtl/bitwise_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bitwise_pkg
//  Description : Shared definitions for the multi-cycle bitwise logic unit:
//                3-bit operation encodings and the sequencer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package bitwise_pkg;

  // Operation select encodings (ctrl_op)
  localparam logic [2:0] OP_NOT  = 3'b000;  // NOT B (legacy)
  localparam logic [2:0] OP_AND  = 3'b001;  // A & B
  localparam logic [2:0] OP_OR   = 3'b010;  // A | B
  localparam logic [2:0] OP_XOR  = 3'b011;  // A ^ B
  localparam logic [2:0] OP_NAND = 3'b100;  // ~(A & B)
  localparam logic [2:0] OP_NOR  = 3'b101;  // ~(A | B)
  localparam logic [2:0] OP_XNOR = 3'b110;  // ~(A ^ B)
  localparam logic [2:0] OP_ANDN = 3'b111;  // A & ~B

  // Sequencer states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage : bitwise_pkg
`default_nettype wire

// File: rtl/bitwise_slice.sv
`default_nettype none
// ============================================================================
//  Module      : bitwise_slice
//  Description : Purely combinational LANE-bit bitwise operator shared by all
//                slices of an operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module bitwise_slice
  import bitwise_pkg::*;
#(
  parameter int LANE = 8
) (
  input  logic [LANE-1:0] a,
  input  logic [LANE-1:0] b,
  input  logic [2:0]      op,
  output logic [LANE-1:0] y
);

  // Select one of the eight bitwise functions for this slice
  always_comb begin
    y = '0;
    case (op)
      OP_NOT:  y = ~b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_ANDN: y = a & ~b;
      default: y = '0;
    endcase
  end

endmodule : bitwise_slice
`default_nettype wire

// File: rtl/bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
//  Module      : bitwise_logic_unit
//  Description : Multi-cycle bitwise logic unit. Operands are captured on
//                ctrl_start and processed LANE bits per cycle through one
//                shared bitwise_slice; the full result is published with a
//                one-cycle data_resultRDY pulse.
//                Optional macro BITWISE_LOGIC_ZERO_FLAG_EN adds data_isZero,
//                registered alongside data_result.
//  Revision    : 1.0 - initial release
// ============================================================================
module bitwise_logic_unit
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANE  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic [2:0]       ctrl_op,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             busy,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY
`ifdef BITWISE_LOGIC_ZERO_FLAG_EN
  ,
  output logic             data_isZero
`endif
);

  localparam int NUM_SLICES = WIDTH / LANE;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  // Bit-offset width: wide enough to address any bit of the operand
  localparam int OFF_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Refuse to elaborate with a lane size that does not tile the operand
  if ((LANE < 1) || ((WIDTH % LANE) != 0)) begin : g_lane_check_fail
    $error("bitwise_logic_unit: WIDTH (%0d) must be a multiple of LANE (%0d)", WIDTH, LANE);
  end

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       op_q,     op_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] work_q,   work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rdy_q,    rdy_d;
`ifdef BITWISE_LOGIC_ZERO_FLAG_EN
  logic             zero_q,   zero_d;
`endif

  logic [OFF_W-1:0] w_off;
  logic [LANE-1:0]  w_slice_a;
  logic [LANE-1:0]  w_slice_b;
  logic [LANE-1:0]  w_slice_y;
  logic             w_last;

  // Current slice position and operand bits, taken from the captured copies
  // so later input changes cannot disturb an in-flight operation.
  assign w_off     = OFF_W'(cnt_q) * OFF_W'(LANE);
  assign w_slice_a = a_q[w_off +: LANE];
  assign w_slice_b = b_q[w_off +: LANE];
  assign w_last    = (cnt_q == CNT_W'(NUM_SLICES - 1));

  bitwise_slice #(
    .LANE (LANE)
  ) u_slice (
    .a  (w_slice_a),
    .b  (w_slice_b),
    .op (op_q),
    .y  (w_slice_y)
  );

  // Next-state logic: capture in IDLE, one slice per cycle in BUSY
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    result_d = result_q;
    rdy_d    = 1'b0;
`ifdef BITWISE_LOGIC_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_start) begin
          a_d     = data_operandA;
          b_d     = data_operandB;
          op_d    = ctrl_op;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        work_d[w_off +: LANE] = w_slice_y;
        cnt_d                 = cnt_q + CNT_W'(1);
        if (w_last) begin
          // Publish the whole word at once; partial slices never leak out
          result_d = work_d;
          rdy_d    = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
`ifdef BITWISE_LOGIC_ZERO_FLAG_EN
          zero_d   = (work_d == '0);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      result_q <= '0;
      rdy_q    <= 1'b0;
`ifdef BITWISE_LOGIC_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
`ifdef BITWISE_LOGIC_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign busy           = (state_q == ST_BUSY);
  assign data_result    = result_q;
  assign data_resultRDY = rdy_q;
`ifdef BITWISE_LOGIC_ZERO_FLAG_EN
  assign data_isZero    = zero_q;
`endif

endmodule : bitwise_logic_unit
`default_nettype wire

// File: doc/bitwise_logic_unit.md
Name: bitwise_logic_unit

Overview:
- Multi-cycle, parametrised bitwise logic unit for the processor ALU. It generalises the fixed 32-bit NOT into eight selectable bitwise operations on WIDTH-bit operands.
- To save area, it processes operands LANE bits per cycle through one shared slice datapath, sequenced by a small FSM and slice counter.
- It uses a start / busy / result-ready handshake, the same style as the other multi-cycle ALU units (mult/div).

Parameters:
- WIDTH, 32, operand and result width in bits.
- LANE, 8, bits processed per cycle. WIDTH mod LANE must be 0; elaboration fails otherwise.
- Derived localparam NUM_SLICES = WIDTH/LANE. Slice counter width is clog2(NUM_SLICES), minimum 1.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ctrl_start  in  1  request a new operation; sampled only in IDLE.
- ctrl_op  in  3  operation select, captured with ctrl_start.
- data_operandA  in  WIDTH  operand A, captured with ctrl_start.
- data_operandB  in  WIDTH  operand B, captured with ctrl_start.
- busy  out  1  high while in BUSY.
- data_result  out  WIDTH  last completed result; held stable between completions.
- data_resultRDY  out  1  one-cycle pulse when data_result has been updated.

Behaviour:
- Reset: synchronous, active-high; clock and reset as named above.
  - On reset: FSM=IDLE, counter=0, working register=0, captured A/B/op=0, data_result=0, data_resultRDY=0, busy=0.
  - Reset asserted mid-operation abandons the operation. No RDY pulse; data_result becomes 0.
- ctrl_op encoding:
  - 000 NOT B (legacy behaviour)
  - 001 A AND B
  - 010 A OR B
  - 011 A XOR B
  - 100 NAND
  - 101 NOR
  - 110 XNOR
  - 111 A AND NOT B
- FSM states: IDLE, BUSY.
- IDLE:
  - On ctrl_start=1 at edge k: capture A, B and op; counter := 0; go BUSY.
  - Otherwise remain in IDLE.
- BUSY:
  - Each edge computes slice idx = counter, i.e. bits [idx*LANE +: LANE], of the captured operands.
  - The slice is written into the same bit positions of the working register. counter := counter+1.
  - On the edge processing idx = NUM_SLICES-1:
    - data_result := working register with the final slice merged in.
    - data_resultRDY := 1.
    - counter := 0; state := IDLE.
- Latency: start sampled at edge k; data_result and data_resultRDY are valid after edge k+NUM_SLICES. With LANE=WIDTH, latency is 1.
- data_resultRDY is high for exactly one cycle, then returns to 0.
- Back-to-back operation: ctrl_start is accepted in the cycle data_resultRDY is high, because the FSM is already IDLE. The next result follows NUM_SLICES edges later.
- ctrl_start while BUSY is ignored; no queuing.
- Input changes after capture do not affect the in-flight operation.
- data_result changes only on completion or reset, never with partial slices.
- Slice datapath is purely combinational; no other pipeline stages.

Optional Feature:
- Macro: BITWISE_LOGIC_ZERO_FLAG_EN.
- Defined:
  - Adds output port data_isZero (out, 1).
  - It is registered together with data_result and equals 1 iff the completed result is all zeros.
  - Reset value 0; held until the next completion.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package bitwise_pkg:
  - 3-bit op encoding constants (OP_NOT, OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_ANDN).
  - FSM state type and encodings (ST_IDLE, ST_BUSY).
- Sub-module bitwise_slice: combinational, parameter LANE; inputs a, b, op; output y.
- Top level holds the FSM, counter, capture registers, working register and result register.

Test Plan:
1. WIDTH=32, LANE=8. Reset, then start with op=000, B=32'h0000FFFF -> busy for 4 cycles; data_result=32'hFFFF0000; RDY pulses once, after edge 4.
2. op=011, A=32'hA5A5A5A5, B=32'h0F0F0F0F -> 32'hAAAAAAAA. Then immediate restart in the RDY cycle with op=111, A=32'hFFFFFFFF, B=32'h12345678 -> 32'hEDCBA987, four edges later.
3. ctrl_start and operand changes (A=B=0) while BUSY -> ignored. The in-flight op=001, A=32'hFF00FF00, B=32'hF0F0F0F0 completes as 32'hF000F000; there is no second RDY.
4. Reset asserted at the 2nd BUSY cycle of op=101 -> next cycle IDLE, data_result=0, no RDY pulse. A subsequent start then works normally.
5. LANE=32: op=100, A=B=32'hFFFFFFFF -> result 32'h00000000 and RDY after 1 edge. With BITWISE_LOGIC_ZERO_FLAG_EN defined, data_isZero=1.
6. Sweep all 8 ops with random A/B (WIDTH=32, LANE=8, and WIDTH=64, LANE=16) -> data_result matches the reference model for every op; data_result is stable between RDY pulses.
